// File: rtl/wait_event_multi.sv
// wait_event_multi: multi-channel wait-event engine.
// Accepts one wait command at a time (valid/ready), watches one channel for a
// masked rise, fall, level match or change, and reports status plus elapsed
// cycles with a one-cycle done pulse.
// Optional feature macro: WAIT_EVENT_MULTI_SYNC_EN adds a two-flop input
// synchroniser in front of the sample register.
module wait_event_multi #(
    parameter int NB_CH     = 5,
    parameter int WIDTH     = 32,
    parameter int TIMEOUT_W = 32,
    parameter int CH_W      = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NB_CH*WIDTH-1:0] i_wait,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [CH_W-1:0]        i_cmd_ch,
    input  logic [1:0]             i_cmd_mode,
    input  logic [WIDTH-1:0]       i_cmd_mask,
    input  logic [WIDTH-1:0]       i_cmd_value,
    input  logic [TIMEOUT_W-1:0]   i_cmd_timeout,
    input  logic                   i_abort,
    output logic                   o_done,
    output logic [1:0]             o_status,
    output logic [TIMEOUT_W-1:0]   o_elapsed,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CH_W:0] NB_CH_L = (CH_W + 1)'(NB_CH);

    state_t                 state_reg, state_next;
    logic [CH_W-1:0]        ch_reg;
    logic [1:0]             mode_reg;
    logic [WIDTH-1:0]       mask_reg;
    logic [WIDTH-1:0]       value_reg;
    logic [TIMEOUT_W-1:0]   timeout_reg;
    logic [TIMEOUT_W-1:0]   cnt_reg, cnt_next;
    logic [NB_CH*WIDTH-1:0] prev_reg;
    logic [NB_CH*WIDTH-1:0] data;
    logic                   ready_reg, done_reg, busy_reg;
    logic [1:0]             status_reg, status_next;
    logic [TIMEOUT_W-1:0]   elapsed_reg, elapsed_next;
    logic [WIDTH-1:0]       cur_arr  [NB_CH];
    logic [WIDTH-1:0]       prev_arr [NB_CH];
    logic [WIDTH-1:0]       cur_ch, prev_ch;
    logic                   accept, hit;

`ifdef WAIT_EVENT_MULTI_SYNC_EN
    logic [NB_CH*WIDTH-1:0] sync1_reg, sync2_reg;

    // Two-flop synchroniser on the watched signals
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= i_wait;
            sync2_reg <= sync1_reg;
        end
    end
    assign data = sync2_reg;
`else
    assign data = i_wait;
`endif

    // Split the flat buses into per-channel words
    generate
        for (genvar gi = 0; gi < NB_CH; gi++) begin : g_ch
            assign cur_arr[gi]  = data[gi*WIDTH +: WIDTH];
            assign prev_arr[gi] = prev_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Select the latched channel; out-of-range indices never reach WAIT
    always_comb begin
        cur_ch  = '0;
        prev_ch = '0;
        for (int c = 0; c < NB_CH; c++) begin
            if (ch_reg == CH_W'(c)) begin
                cur_ch  = cur_arr[c];
                prev_ch = prev_arr[c];
            end
        end
    end

    // Hit condition for the latched mode
    always_comb begin
        hit = 1'b0;
        case (mode_reg)
            2'd0:    hit = |(~prev_ch & cur_ch & mask_reg);
            2'd1:    hit = |(prev_ch & ~cur_ch & mask_reg);
            2'd2:    hit = ((cur_ch & mask_reg) == (value_reg & mask_reg));
            default: hit = |((prev_ch ^ cur_ch) & mask_reg);
        endcase
    end

    assign accept = i_cmd_valid & ready_reg;

    // Next state, result and cycle counter; hit beats timeout beats abort
    always_comb begin
        state_next   = state_reg;
        status_next  = status_reg;
        elapsed_next = elapsed_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if ({1'b0, i_cmd_ch} >= NB_CH_L) begin
                        state_next   = S_DONE;
                        status_next  = 2'b11;
                        elapsed_next = '0;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = '0;
                    end
                end
            end
            S_WAIT: begin
                if (hit) begin
                    state_next   = S_DONE;
                    status_next  = 2'b00;
                    elapsed_next = cnt_reg;
                end else if ((timeout_reg != '0) &&
                             (cnt_reg == timeout_reg - TIMEOUT_W'(1))) begin
                    state_next   = S_DONE;
                    status_next  = 2'b01;
                    elapsed_next = timeout_reg;
                end else if (i_abort) begin
                    state_next   = S_DONE;
                    status_next  = 2'b10;
                    elapsed_next = cnt_reg;
                end else if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + TIMEOUT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, command latch, sample register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            ch_reg      <= '0;
            mode_reg    <= '0;
            mask_reg    <= '0;
            value_reg   <= '0;
            timeout_reg <= '0;
            cnt_reg     <= '0;
            prev_reg    <= '0;
            ready_reg   <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            status_reg  <= 2'b00;
            elapsed_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            prev_reg    <= data;
            ready_reg   <= (state_next == S_IDLE);
            done_reg    <= (state_next == S_DONE);
            busy_reg    <= (state_next != S_IDLE);
            status_reg  <= status_next;
            elapsed_reg <= elapsed_next;
            if (accept) begin
                ch_reg      <= i_cmd_ch;
                mode_reg    <= i_cmd_mode;
                mask_reg    <= i_cmd_mask;
                value_reg   <= i_cmd_value;
                timeout_reg <= i_cmd_timeout;
            end
        end
    end

    assign o_cmd_ready = ready_reg;
    assign o_done      = done_reg;
    assign o_busy      = busy_reg;
    assign o_status    = status_reg;
    assign o_elapsed   = elapsed_reg;

endmodule

// File: doc/wait_event_multi.md
# wait_event_multi

Multi-channel wait-event engine for the testbench sequencer: it accepts one wait command at a time through a valid/ready handshake and watches a selected input channel for a masked edge, level match or change. It reports completion with a status code and the elapsed cycle count. It is the parametrised successor of the single-bit wait-event path and adds per-command mode, mask, compare value, timeout, abort and an error status. It sits between the sequencer wrapper and the DUT outputs in the testbench top.

## Interface
- NB_CH, 5, number of watched channels (>=1)
- WIDTH, 32, bits per channel
- TIMEOUT_W, 32, width of timeout and elapsed counters
- CH_W, $clog2(NB_CH) (min 1), channel index width (derived)
- clk  in  1  testbench clock
- rst_n  in  1  reset, asynchronous, active-low
- i_wait  in  NB_CH*WIDTH  watched signals; channel c occupies bits [c*WIDTH +: WIDTH]
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  engine idle and able to accept a command
- i_cmd_ch  in  CH_W  channel index
- i_cmd_mode  in  2  0 = rise, 1 = fall, 2 = level match, 3 = any change
- i_cmd_mask  in  WIDTH  bits that take part in the evaluation
- i_cmd_value  in  WIDTH  compare value, used in mode 2 only
- i_cmd_timeout  in  TIMEOUT_W  timeout in cycles; 0 = wait forever
- i_abort  in  1  cancels the active wait
- o_done  out  1  one-cycle completion pulse
- o_status  out  2  00 hit, 01 timeout, 10 aborted, 11 error (bad channel)
- o_elapsed  out  TIMEOUT_W  number of WAIT cycles consumed before completion
- o_busy  out  1  a command is active

## Operation
- The FSM has three states: IDLE, WAIT and DONE.
- Command acceptance:
  - A command is accepted on a rising edge where i_cmd_valid & o_cmd_ready. All command fields are latched at that edge.
  - If i_cmd_ch >= NB_CH: IDLE -> DONE with status 11 and elapsed 0.
  - Otherwise: IDLE -> WAIT, elapsed counter cleared.
- Sampling: the sample register prev[c] copies the channel data every cycle, in every state. cur denotes the channel data in the current cycle.
- Hit condition, evaluated in each WAIT cycle on the latched channel:
  - rise: |(~prev & cur & mask)
  - fall: |(prev & ~cur & mask)
  - level match: (cur & mask) == (value & mask)
  - change: |((prev ^ cur) & mask)
- Mask = 0: modes rise, fall and change never hit. Level match hits on the first WAIT cycle.
- WAIT cycles are numbered k = 0, 1, 2, ... with k = 0 being the cycle after acceptance.
  - Hit in cycle k: WAIT -> DONE, status 00, elapsed = k.
  - Timeout N > 0 with no hit in cycles 0..N-1: WAIT -> DONE at the end of cycle N-1, status 01, elapsed = N.
  - i_abort in a WAIT cycle: WAIT -> DONE, status 10, elapsed = k.
  - Priority within one cycle: hit > timeout > abort.
  - i_abort outside WAIT is ignored.
- DONE lasts one cycle:
  - o_done = 1; o_status and o_elapsed are valid during it.
  - Then DONE -> IDLE.
  - o_status and o_elapsed hold their values until the next DONE.
- The elapsed counter saturates at all-ones and does not wrap (relevant for timeout = 0).

## Timing
- All outputs are registered.
- Reset values: o_cmd_ready 0, o_done 0, o_status 00, o_elapsed 0, o_busy 0, state IDLE, prev 0.
- o_cmd_ready rises on the first clk edge after rst_n deasserts. It is 1 in IDLE only.
- o_busy is 1 in WAIT and DONE.
- Latency, hit at the earliest possible point:
  - Command accepted at edge T.
  - First evaluation in cycle T+1.
  - o_done high in cycle T+2.
  - o_cmd_ready high again from T+3.
- Back-to-back commands: one accepted command per minimum 3 cycles.
- Bad channel: o_done high in cycle T+1.
- Reset mid-operation: everything returns immediately to the reset values. The active command is dropped and no o_done is produced.
- Edge reference at k = 0 is the sample taken in the acceptance cycle. An edge coinciding with acceptance is therefore not seen, but an edge into cycle T+1 is.

## Configuration
- WAIT_EVENT_MULTI_SYNC_EN defined: i_wait passes through a two-flop synchroniser (reset 0) before prev/cur. Input-to-hit latency grows by 2 cycles. Command and handshake timing are unchanged.
- WAIT_EVENT_MULTI_SYNC_EN undefined: i_wait is used directly.

## Test plan
- Rise: NB_CH = 5, WIDTH = 32, ch 2, mask 0x1, timeout 0; drive ch2 bit0 0->1 five cycles after acceptance -> o_done with status 00, elapsed 4.
- Level already true: ch 0 = 0xCAFEDECA, mode 2, value 0xCAFE0000, mask 0xFFFF0000 -> done at T+2, status 00, elapsed 0.
- Timeout: mode 0, timeout 10, channel static -> status 01, elapsed 10, o_done 11 cycles after acceptance; hit in cycle 9 instead -> status 00, elapsed 9.
- Abort and hit in the same cycle -> status 00. Abort alone at k = 3 -> status 10, elapsed 3.
- Bad channel: i_cmd_ch = 6 -> done at T+1, status 11. Next command accepted at T+2 is processed normally.
- Reset mid-WAIT: assert rst_n low -> outputs zero, no o_done, o_cmd_ready high one edge after release. With WAIT_EVENT_MULTI_SYNC_EN defined, repeat the rise test -> elapsed 6.
